// File: rtl/glyph_table_streamer.sv
// rtl/glyph_table_streamer.sv - writable glyph row table with registered read port and burst streamer
//
// Purpose: GLYPHS x ROWS table of COLS-pixel rows. The host writes rows at any time, reads any row with
//          one cycle of latency, or requests a burst that streams a glyph range as valid/ready beats.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data     row write port (address = glyph*ROWS + row)
//   rd_addr/rd_data           random-read port, rd_data registered, zero-padded to DATA_W
//   start/first_glyph/
//   glyph_count               burst request, sampled only while idle
//   busy/done/err             burst status; done and err are one-cycle pulses
//   s_valid/s_ready/s_data/
//   s_addr/s_last             outgoing row stream
module glyph_table_streamer #(
    parameter int    GLYPHS    = 8,
    parameter int    ROWS      = 8,
    parameter int    COLS      = 5,
    parameter int    DATA_W    = 8,
    parameter string INIT_FILE = "",
    localparam int   DEPTH     = GLYPHS * ROWS,
    localparam int   AW        = $clog2(DEPTH),
    localparam int   GW        = $clog2(GLYPHS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [COLS-1:0]   wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic              start,
    input  logic [AW-1:0]     first_glyph,
    input  logic [GW-1:0]     glyph_count,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              s_valid,
    input  logic              s_ready,
    output logic [DATA_W-1:0] s_data,
    output logic [AW-1:0]     s_addr,
    output logic              s_last
);

    localparam int BW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;

    state_t            state_q, state_d;
    logic [COLS-1:0]   mem [DEPTH];
    logic [AW-1:0]     ptr_q, ptr_d, ptr_next;
    logic [BW-1:0]     beats_q, beats_d;   // beats remaining, including the one currently loaded
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [DATA_W-1:0] s_data_q, s_data_d;
    logic [AW-1:0]     s_addr_q, s_addr_d;
    logic              s_valid_q, s_valid_d;
    logic              s_last_q, s_last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    // Power-up image; the table itself is never touched by reset.
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    end

    always_ff @(posedge clk) begin
        if (wr_en && (32'(wr_addr) < DEPTH)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        beats_d   = beats_q;
        s_data_d  = s_data_q;
        s_addr_d  = s_addr_q;
        s_valid_d = s_valid_q;
        s_last_d  = s_last_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        rd_data_d = (32'(rd_addr) < DEPTH) ? DATA_W'(mem[rd_addr]) : '0;
        ptr_next  = (32'(ptr_q) == DEPTH - 1) ? '0 : ptr_q + 1'b1;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (32'(first_glyph) >= GLYPHS) begin
                        err_d = 1'b1;
                    end else if (glyph_count == '0) begin
                        state_d = DONE;
                    end else begin
                        ptr_d   = AW'(32'(first_glyph) * ROWS);
                        beats_d = BW'(((32'(glyph_count) > GLYPHS) ? GLYPHS : 32'(glyph_count)) * ROWS);
                        busy_d  = 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                s_data_d  = DATA_W'(mem[ptr_q]);
                s_addr_d  = ptr_q;
                s_valid_d = 1'b1;
                s_last_d  = (beats_q == BW'(1));
                state_d   = SEND;
            end
            SEND: begin
                if (s_valid_q && s_ready) begin
                    if (s_last_q) begin
                        s_valid_d = 1'b0;
                        s_last_d  = 1'b0;
                        state_d   = DONE;
                    end else begin
                        // Next row loads on the accepting edge, so the stream never bubbles.
                        ptr_d    = ptr_next;
                        beats_d  = beats_q - 1'b1;
                        s_data_d = DATA_W'(mem[ptr_next]);
                        s_addr_d = ptr_next;
                        s_last_d = (beats_q == BW'(2));
                    end
                end
            end
            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            beats_q   <= '0;
            rd_data_q <= '0;
            s_data_q  <= '0;
            s_addr_q  <= '0;
            s_valid_q <= 1'b0;
            s_last_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            beats_q   <= beats_d;
            rd_data_q <= rd_data_d;
            s_data_q  <= s_data_d;
            s_addr_q  <= s_addr_d;
            s_valid_q <= s_valid_d;
            s_last_q  <= s_last_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign rd_data = rd_data_q;
    assign s_data  = s_data_q;
    assign s_addr  = s_addr_q;
    assign s_valid = s_valid_q;
    assign s_last  = s_last_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_glyph_table_streamer.sv
// tb/tb_glyph_table_streamer.sv - self-checking bench for glyph_table_streamer
module tb_glyph_table_streamer;

    localparam int GLYPHS = 8;
    localparam int ROWS   = 8;
    localparam int DEPTH  = 64;

    logic       clk = 1'b0;
    logic       rst, wr_en, start, s_ready;
    logic [5:0] wr_addr, rd_addr, first_glyph, s_addr;
    logic [4:0] wr_data;
    logic [3:0] glyph_count;
    logic [7:0] rd_data, s_data;
    logic       busy, done, err, s_valid, s_last;

    int total = 0;
    int bad   = 0;
    logic [4:0] model [DEPTH];

    glyph_table_streamer dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .start(start), .first_glyph(first_glyph), .glyph_count(glyph_count),
        .busy(busy), .done(done), .err(err),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_addr(s_addr), .s_last(s_last)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int a, input logic [4:0] d);
        wr_en = 1'b1; wr_addr = 6'(a); wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        model[a] = d;
    endtask

    task automatic rd_check(input int a);
        rd_addr = 6'(a);
        @(negedge clk);
        chk("rd_random", rd_data, 32'(model[a]));
    endtask

    // mode: 0 always ready, 1 ready 1,0,1,0..., 2 random ready
    task automatic burst(input int first, input int cnt, input int mode,
                         input int rst_beat, input bit mid_start, input bit wr_loaded);
        int nbeats, idx, cyc;
        bit rdy;
        logic [5:0] eaddr [$];
        logic [4:0] edata [$];
        nbeats = ((cnt > GLYPHS) ? GLYPHS : cnt) * ROWS;
        if (first < GLYPHS) begin
            for (int i = 0; i < nbeats; i++) begin
                eaddr.push_back(6'((first * ROWS + i) % DEPTH));
                edata.push_back(model[(first * ROWS + i) % DEPTH]);
            end
        end
        start = 1'b1; first_glyph = 6'(first); glyph_count = 4'(cnt); s_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        if (first >= GLYPHS) begin
            chk("err_pulse", err, 1); chk("err_busy", busy, 0);
            @(negedge clk);
            chk("err_clear", err, 0); chk("err_busy_after", busy, 0); chk("err_valid", s_valid, 0);
            return;
        end
        if (cnt == 0) begin
            chk("zero_done_early", done, 0); chk("zero_busy", busy, 0);
            @(negedge clk);
            chk("zero_done", done, 1); chk("zero_valid", s_valid, 0); chk("zero_busy2", busy, 0);
            @(negedge clk);
            chk("zero_done_clear", done, 0); chk("zero_valid2", s_valid, 0);
            return;
        end
        chk("b_busy", busy, 1); chk("b_valid_early", s_valid, 0);
        @(negedge clk);
        idx = 0; cyc = 0;
        while (idx < nbeats && cyc < 400) begin
            chk("b_valid", s_valid, 1);
            chk("b_addr", s_addr, 32'(eaddr[idx]));
            chk("b_data", s_data, 32'(edata[idx]));
            chk("b_last", s_last, 32'(idx == nbeats - 1));
            chk("b_busy_mid", busy, 1);
            chk("b_done_mid", done, 0);
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            s_ready = rdy;
            if (mid_start && cyc == 3) begin
                start = 1'b1; first_glyph = 6'd2; glyph_count = 4'd1;
            end else begin
                start = 1'b0;
            end
            if (wr_loaded && cyc == 1) begin
                wr_en = 1'b1; wr_addr = eaddr[idx]; wr_data = ~edata[idx];
                model[eaddr[idx]] = ~edata[idx];
            end else begin
                wr_en = 1'b0;
            end
            if (rdy) idx++;
            cyc++;
            if (rst_beat > 0 && idx == rst_beat) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0; s_ready = 1'b0; start = 1'b0; wr_en = 1'b0;
                chk("rst_valid", s_valid, 0); chk("rst_busy", busy, 0);
                chk("rst_last", s_last, 0); chk("rst_addr", s_addr, 0); chk("rst_data", s_data, 0);
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk("rst_no_done", done, 0); chk("rst_busy_low", busy, 0);
                end
                return;
            end
            @(negedge clk);
        end
        start = 1'b0; wr_en = 1'b0;
        chk("b_beat_count", idx, nbeats);
        chk("end_valid", s_valid, 0); chk("end_last", s_last, 0);
        chk("end_done_early", done, 0); chk("end_busy", busy, 1);
        @(negedge clk);
        chk("end_done", done, 1); chk("end_busy_low", busy, 0);
        @(negedge clk);
        chk("end_done_clear", done, 0); chk("end_busy_idle", busy, 0);
    endtask

    initial begin
        logic [4:0] old_v, new_v;
        rst = 1'b1; wr_en = 1'b0; start = 1'b0; s_ready = 1'b0;
        wr_addr = '0; wr_data = '0; rd_addr = '0; first_glyph = '0; glyph_count = '0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_rd_data", rd_data, 0); chk("reset_s_data", s_data, 0);
        chk("reset_s_addr", s_addr, 0); chk("reset_busy", busy, 0);
        chk("reset_done", done, 0); chk("reset_err", err, 0);
        chk("reset_s_valid", s_valid, 0); chk("reset_s_last", s_last, 0);
        rst = 1'b0;

        for (int a = 0; a < DEPTH; a++) wr(a, 5'($urandom));

        // T1: fixed pattern, registered read, read-first on same-address write
        for (int a = 16; a < 24; a++) wr(a, 5'b10101);
        rd_addr = 6'd16;
        @(negedge clk);
        chk("t1_rd16", rd_data, 32'h15);
        old_v = model[3]; new_v = ~old_v;
        wr_en = 1'b1; wr_addr = 6'd3; wr_data = new_v; rd_addr = 6'd3;
        @(negedge clk);
        wr_en = 1'b0;
        chk("t1_read_first", rd_data, 32'(old_v));
        model[3] = new_v;
        @(negedge clk);
        chk("t1_read_new", rd_data, 32'(new_v));
        for (int i = 0; i < 8; i++) rd_check(int'($urandom_range(0, DEPTH - 1)));

        burst(0, 2, 0, 0, 0, 0);   // T2
        burst(3, 1, 1, 0, 0, 1);   // T3, stalls plus write to a held beat
        burst(7, 2, 0, 0, 1, 0);   // T4, wrap and ignored mid-burst start
        burst(4, 0, 0, 0, 0, 0);   // T5 zero count
        burst(9, 2, 0, 0, 0, 0);   // T5 bad first glyph
        burst(1, 3, 0, 5, 0, 0);   // T6 reset mid-burst
        burst(1, 3, 2, 0, 0, 0);   // T6 fresh start
        burst(5, 12, 2, 0, 0, 0);  // count above GLYPHS clamps

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 4; i++) wr(int'($urandom_range(0, DEPTH - 1)), 5'($urandom));
            burst(int'($urandom_range(0, 9)), int'($urandom_range(0, 8)), 2, 0, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
